// File: rtl/pdm_mic_capture.sv
// rtl/pdm_mic_capture.sv - PDM mic front end: bit clock, boxcar decimation, FWFT sample FIFO
module pdm_mic_capture #(
    parameter int CLK_DIV  = 8,
    parameter int DECIM    = 64,
    parameter int DEPTH    = 16,
    localparam int SAMPLE_W = $clog2(DECIM) + 1,
    localparam int LVL_W    = $clog2(DEPTH) + 1
) (
    input  logic                mclk,
    input  logic                reset,
    input  logic                enable,
    input  logic                stereo,
    input  logic                mono_ch,
    output logic                pdm_clk,
    input  logic                pdm_data,
    output logic [SAMPLE_W-1:0] pcm_data,
    output logic                pcm_chan,
    output logic                pcm_valid,
    input  logic                pcm_ready,
    output logic [LVL_W-1:0]    fifo_level,
    output logic                overflow,
    input  logic                clear_ovf
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DECIM);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0]       CNT_L    = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0]       CNT_R    = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0]       BIT_LAST = BW'(DECIM - 1);
    localparam logic [SAMPLE_W-1:0] MID      = SAMPLE_W'(DECIM / 2);
    localparam logic [LVL_W-1:0]    FULL_LVL = LVL_W'(DEPTH);

    logic [CW-1:0]       cnt, cnt_nxt;
    logic [BW-1:0]       bit_cnt;
    logic [SAMPLE_W-1:0] acc_l, acc_r, sum_l, sum_r, ds_ext, wr_sample;
    logic                sync1, ds, en_q, mode_stereo, mode_ch;
    logic                l_take, r_take, last_bit, wr_req, wr_chan;

    assign cnt_nxt   = (cnt == CNT_R) ? '0 : cnt + 1'b1;
    assign l_take    = enable && (cnt == CNT_L) && (mode_stereo || !mode_ch);
    assign r_take    = enable && (cnt == CNT_R) && (mode_stereo || mode_ch);
    assign last_bit  = (bit_cnt == BIT_LAST);
    assign ds_ext    = {{(SAMPLE_W-1){1'b0}}, ds};
    assign sum_l     = acc_l + ds_ext;
    assign sum_r     = acc_r + ds_ext;
    // L and R sample cycles are half a period apart, so at most one write per cycle
    assign wr_req    = (l_take || r_take) && last_bit;
    assign wr_chan   = r_take;
    assign wr_sample = (r_take ? sum_r : sum_l) - MID;

    always_ff @(posedge mclk) begin
        if (reset) begin
            sync1       <= 1'b0;
            ds          <= 1'b0;
            en_q        <= 1'b0;
            mode_stereo <= 1'b0;
            mode_ch     <= 1'b0;
            cnt         <= '0;
            pdm_clk     <= 1'b0;
            bit_cnt     <= '0;
            acc_l       <= '0;
            acc_r       <= '0;
        end else begin
            sync1 <= pdm_data;
            ds    <= sync1;
            en_q  <= enable;
            if (enable && !en_q) begin
                mode_stereo <= stereo;
                mode_ch     <= mono_ch;
            end
            if (!enable) begin
                cnt     <= '0;
                pdm_clk <= 1'b0;
                bit_cnt <= '0;
                acc_l   <= '0;
                acc_r   <= '0;
            end else begin
                cnt     <= cnt_nxt;
                pdm_clk <= (cnt_nxt <= CNT_L);
                if (cnt == CNT_R)
                    bit_cnt <= bit_cnt + 1'b1;
                if (l_take)
                    acc_l <= last_bit ? '0 : sum_l;
                if (r_take)
                    acc_r <= last_bit ? '0 : sum_r;
            end
        end
    end

    logic [SAMPLE_W:0]   mem [DEPTH];
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [LVL_W-1:0]    level;
    logic [SAMPLE_W:0]   head;
    logic                full, push, pop;

    assign full = (level == FULL_LVL);
    assign pop  = pcm_valid && pcm_ready;
    // a pop in the same cycle frees the slot, so a write at full is still accepted
    assign push = wr_req && (!full || pop);

    always_ff @(posedge mclk) begin
        if (push && !reset)
            mem[wr_ptr] <= {wr_chan, wr_sample};
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (wr_req && full && !pop)
                overflow <= 1'b1;
            else if (clear_ovf)
                overflow <= 1'b0;
        end
    end

    assign head       = mem[rd_ptr];
    assign pcm_valid  = (level != '0);
    assign pcm_data   = pcm_valid ? head[SAMPLE_W-1:0] : '0;
    assign pcm_chan   = pcm_valid & head[SAMPLE_W];
    assign fifo_level = level;

endmodule

// File: tb/tb_pdm_mic_capture.sv
// tb/tb_pdm_mic_capture.sv - scoreboard bench for pdm_mic_capture (CLK_DIV=8, DECIM=8, DEPTH=4)
module tb_pdm_mic_capture;

    logic       mclk = 1'b0;
    logic       reset, enable, stereo, mono_ch, pdm_data, pcm_ready, clear_ovf;
    logic       pdm_clk, pcm_chan, pcm_valid, overflow;
    logic [3:0] pcm_data;
    logic [2:0] fifo_level;

    pdm_mic_capture #(.CLK_DIV(8), .DECIM(8), .DEPTH(4)) dut (
        .mclk(mclk), .reset(reset), .enable(enable), .stereo(stereo), .mono_ch(mono_ch),
        .pdm_clk(pdm_clk), .pdm_data(pdm_data), .pcm_data(pcm_data), .pcm_chan(pcm_chan),
        .pcm_valid(pcm_valid), .pcm_ready(pcm_ready), .fifo_level(fifo_level),
        .overflow(overflow), .clear_ovf(clear_ovf)
    );

    always #5 mclk = ~mclk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int pat     = 0;
    int exp_q[$];

    // expected head encoding: {chan, 4-bit sample}
    localparam int L_POS = 5'b00100;
    localparam int L_ZERO = 5'b00000;
    localparam int L_NEG = 5'b01100;
    localparam int R_NEG = 5'b11100;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // pdm_data driven in cycle c is the bit seen at the sample edge of cycle c+2
    function automatic logic pat_bit(input int c);
        case (pat)
            0:       return 1'b1;
            1:       return 1'(((c + 2) / 8) % 2);
            2:       return 1'b0;
            default: return 1'(((c + 2) % 8) < 4);
        endcase
    endfunction

    task automatic step();
        pdm_data = pat_bit(cyc);
        if (pcm_valid && pcm_ready) begin
            if (exp_q.size() == 0)
                check("sb_extra", int'({pcm_chan, pcm_data}), -1);
            else
                check("sample", int'({pcm_chan, pcm_data}), exp_q.pop_front());
        end
        @(posedge mclk);
        #1;
        if (enable) cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic begin_run(input logic st, input logic ch);
        stereo  = st;
        mono_ch = ch;
        enable  = 1'b1;
        cyc     = 0;
    endtask

    task automatic idle(input int n);
        enable = 1'b0;
        repeat (n) step();
    endtask

    task automatic push_n(input int n, input int v);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; stereo = 1'b0; mono_ch = 1'b0;
        pdm_data = 1'b0; pcm_ready = 1'b1; clear_ovf = 1'b0;
        repeat (3) @(posedge mclk);
        #1;
        reset = 1'b0;
        check("rst_pdm_clk", pdm_clk, 0);
        check("rst_valid", pcm_valid, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ovf", overflow, 0);
        check("rst_data", pcm_data, 0);
        check("rst_chan", pcm_chan, 0);
        idle(3);

        // mono L, constant ones
        pat = 0;
        push_n(3, L_POS);
        begin_run(1'b0, 1'b0);
        run_to(3);   check("pdm_clk_hi", pdm_clk, 1);
        run_to(4);   check("pdm_clk_lo", pdm_clk, 0);
        run_to(59);  check("t1_valid59", pcm_valid, 0);
        run_to(60);
        check("t1_valid60", pcm_valid, 1);
        check("t1_data60", pcm_data, 4);
        check("t1_chan60", pcm_chan, 0);
        check("t1_level60", fifo_level, 1);
        run_to(123); check("t1_valid123", pcm_valid, 0);
        run_to(124); check("t1_valid124", pcm_valid, 1);
        run_to(190);
        idle(4);
        check("t1_drained", exp_q.size(), 0);

        // alternating periods then all zeros
        pat = 1;
        push_n(2, L_ZERO);
        begin_run(1'b0, 1'b0);
        run_to(130);
        idle(4);
        pat = 2;
        push_n(2, L_NEG);
        begin_run(1'b0, 1'b0);
        run_to(130);
        idle(4);
        check("t2_drained", exp_q.size(), 0);

        // stereo, ones on L sample cycles, zeros on R
        pat = 3;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(L_POS);
            exp_q.push_back(R_NEG);
        end
        begin_run(1'b1, 1'b0);
        run_to(60);  check("t3_L_valid", pcm_valid, 1); check("t3_L_chan", pcm_chan, 0);
        run_to(63);  check("t3_gap_valid", pcm_valid, 0);
        run_to(64);  check("t3_R_valid", pcm_valid, 1); check("t3_R_chan", pcm_chan, 1);
        check("t3_R_data", pcm_data, 12);
        run_to(130);
        idle(4);
        check("t3_drained", exp_q.size(), 0);

        // overflow: fifth sample dropped with ready low
        pat = 0;
        pcm_ready = 1'b0;
        push_n(4, L_POS);
        begin_run(1'b0, 1'b0);
        run_to(252); check("t4_level_full", fifo_level, 4);
        run_to(315); check("t4_ovf_before", overflow, 0);
        step();
        check("t4_ovf_set", overflow, 1);
        check("t4_level_keep", fifo_level, 4);
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        check("t4_ovf_clr", overflow, 0);
        enable = 1'b0;
        pcm_ready = 1'b1;
        idle(6);
        check("t4_level_drain", fifo_level, 0);
        check("t4_drained", exp_q.size(), 0);

        // fifth write coincides with a pop: accepted
        pcm_ready = 1'b0;
        push_n(5, L_POS);
        begin_run(1'b0, 1'b0);
        run_to(315); check("t4b_level", fifo_level, 4);
        pcm_ready = 1'b1;
        step();
        pcm_ready = 1'b0;
        check("t4b_level_keep", fifo_level, 4);
        check("t4b_no_ovf", overflow, 0);
        enable = 1'b0;
        pcm_ready = 1'b1;
        idle(6);
        check("t4b_drained", exp_q.size(), 0);

        // disable mid-window, re-enable in stereo; mode changes while running ignored
        pat = 0;
        begin_run(1'b0, 1'b0);
        run_to(30);
        idle(1);
        check("t5_pdm_clk_off", pdm_clk, 0);
        idle(10);
        check("t5_pdm_clk_off2", pdm_clk, 0);
        check("t5_no_partial", fifo_level, 0);
        pat = 3;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(L_POS);
            exp_q.push_back(R_NEG);
        end
        begin_run(1'b1, 1'b0);
        run_to(2);
        stereo = 1'b0;
        mono_ch = 1'b1;
        run_to(59);  check("t5_valid59", pcm_valid, 0);
        run_to(60);  check("t5_valid60", pcm_valid, 1); check("t5_data60", pcm_data, 4);
        run_to(130);
        idle(4);
        check("t5_drained", exp_q.size(), 0);

        // reset mid-window with three samples held
        pat = 0;
        pcm_ready = 1'b0;
        begin_run(1'b0, 1'b0);
        run_to(200);
        check("t6_level3", fifo_level, 3);
        check("t6_pdm_clk", pdm_clk, 1);
        reset = 1'b1;
        enable = 1'b0;
        step();
        check("t6_valid", pcm_valid, 0);
        check("t6_level", fifo_level, 0);
        check("t6_ovf", overflow, 0);
        check("t6_pdm_clk0", pdm_clk, 0);
        reset = 1'b0;
        step();
        check("t6_level_after", fifo_level, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
